// File: rtl/sync_fifo_pkg.sv
// Shared constants for the per-width FIFO instances in the video/audio-over-Ethernet path.
package sync_fifo_pkg;
  localparam int FIFO_W_VIDEO_TX = 48;
  localparam int FIFO_W_VIDEO_RX = 29;
  localparam int FIFO_W_AUX      = 25;
  localparam int FIFO_ADDR_W     = 9;
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port WIDTH x 2**ADDR_W storage: synchronous write, enable-gated registered read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_W_AUX,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // No reset on the output register so the whole read path stays inside the block RAM.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_w.sv
// Single-clock FIFO with registered read data and registered Empty/Full flags.
module sync_fifo_w
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_W_AUX,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic             fifo_clk,
  input  logic             rstbtn_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] Data,
  input  logic             WrEn,
  input  logic             RdEn,
  output logic [WIDTH-1:0] Q,
  output logic             Empty,
  output logic             Full
);
  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              empty_d, empty_q;
  logic              full_d, full_q;
  logic              live_d, live_q;
  logic              wr_acc, rd_acc;
  logic [WIDTH-1:0]  ram_rdata;

  assign wr_acc = WrEn & ~full_q;
  assign rd_acc = RdEn & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    live_d   = live_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      live_d   = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        live_d   = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      live_q   <= live_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (fifo_clk),
    .we    (wr_acc & ~clr),
    .waddr (wr_ptr_q),
    .wdata (Data),
    .re    (rd_acc & ~clr),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // live_q drops on reset/flush so Q reads as zero until a fresh word is read out.
  assign Q     = ram_rdata & {WIDTH{live_q}};
  assign Empty = empty_q;
  assign Full  = full_q;
endmodule

// File: tb/tb_sync_fifo_w.sv
// Bench driving 25/29/48-bit FIFO instances in lockstep against a queue-based reference model.
module tb_sync_fifo_w;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [47:0] din = '0;

  logic [24:0] q25;
  logic [28:0] q29;
  logic [47:0] q48;
  logic        e25, e29, e48, f25, f29, f48;

  logic [47:0] mq = '0;
  logic [47:0] fifo_m [$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_w #(.WIDTH(25), .ADDR_W(9)) u25 (
    .fifo_clk(clk), .rstbtn_n(rst_n), .clr(clr), .Data(din[24:0]),
    .WrEn(wr), .RdEn(rd), .Q(q25), .Empty(e25), .Full(f25));
  sync_fifo_w #(.WIDTH(29), .ADDR_W(9)) u29 (
    .fifo_clk(clk), .rstbtn_n(rst_n), .clr(clr), .Data(din[28:0]),
    .WrEn(wr), .RdEn(rd), .Q(q29), .Empty(e29), .Full(f29));
  sync_fifo_w #(.WIDTH(48), .ADDR_W(9)) u48 (
    .fifo_clk(clk), .rstbtn_n(rst_n), .clr(clr), .Data(din),
    .WrEn(wr), .RdEn(rd), .Q(q48), .Empty(e48), .Full(f48));

  wire [101:0] obs_q  = {q25, q29, q48};
  wire [5:0]   obs_fl = {e25, e29, e48, f25, f29, f48};

  function automatic logic [101:0] exp_q();
    return {mq[24:0], mq[28:0], mq};
  endfunction

  function automatic logic [5:0] exp_fl();
    logic e, f;
    e = (fifo_m.size() == 0);
    f = (fifo_m.size() == 512);
    return {e, e, e, f, f, f};
  endfunction

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic w, input logic r, input logic c, input logic [47:0] d);
    bit rok, wok;
    wr = w; rd = r; clr = c; din = d;
    @(posedge clk);
    if (c) begin
      fifo_m.delete();
      mq = '0;
    end else begin
      rok = r && (fifo_m.size() > 0);
      wok = w && (fifo_m.size() < 512);
      if (rok) mq = fifo_m.pop_front();
      if (wok) fifo_m.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    fifo_m.delete();
    mq = '0;
    n_cmp++;
    if ({obs_q, obs_fl} !== {exp_q(), exp_fl()} || q48 !== 48'h0 || e25 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: got q=%h fl=%b want q=%h fl=%b", obs_q, obs_fl, exp_q(), exp_fl());
    end
    rst_n = 1'b1;
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    n_cmp++;
    if ({obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL reset_idle: got q=%h fl=%b want q=%h fl=%b", obs_q, obs_fl, exp_q(), exp_fl());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0);
      n_cmp++;
      if (q48 !== 48'h0 || e48 !== 1'b1 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
        n_fail++;
        $display("FAIL reset_rd_empty: got q=%h fl=%b want q=0 empty", obs_q, obs_fl);
      end
    end
  endtask

  task automatic test_ordered();
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 48'(i));
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, '0);
      n_cmp++;
      if (q25 !== 25'(i) || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
        n_fail++;
        $display("FAIL ordered_q[%0d]: got q=%h fl=%b want q25=%h", i, obs_q, obs_fl, 25'(i));
      end
    end
    n_cmp++;
    if (e25 !== 1'b1 || e29 !== 1'b1 || e48 !== 1'b1) begin
      n_fail++;
      $display("FAIL ordered_empty: got %b%b%b want 111", e25, e29, e48);
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 512; k++) step(1, 0, 0, 48'(k));
    n_cmp++;
    if (f48 !== 1'b1 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL fill_full: got fl=%b want fl=%b", obs_fl, exp_fl());
    end
    step(1, 0, 0, 48'hDEADBEEF);
    n_cmp++;
    if (f48 !== 1'b1 || e48 !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_flags: got full=%b empty=%b want full=1 empty=0", f48, e48);
    end
    for (int k = 0; k < 512; k++) begin
      step(0, 1, 0, '0);
      n_cmp++;
      if (q48 !== 48'(k) || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
        n_fail++;
        $display("FAIL fill_read[%0d]: got q=%h fl=%b want q48=%h fl=%b", k, obs_q, obs_fl, 48'(k), exp_fl());
      end
    end
    step(0, 1, 0, '0);
    n_cmp++;
    if (q48 !== 48'd511 || e48 !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_dropped: got q=%h empty=%b want q=1ff empty=1", q48, e48);
    end
  endtask

  task automatic test_simul_boundaries();
    logic [47:0] q_before;
    q_before = q48;
    step(1, 1, 0, 48'h155);
    n_cmp++;
    if (e48 !== 1'b0 || q48 !== q_before || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL simul_empty: got q=%h empty=%b want q=%h empty=0", q48, e48, q_before);
    end
    step(0, 1, 0, '0);
    n_cmp++;
    if (q48 !== 48'h155 || e48 !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_empty_read: got q=%h empty=%b want q=155 empty=1", q48, e48);
    end
    for (int k = 0; k < 512; k++) step(1, 0, 0, rnd48());
    q_before = fifo_m[0];
    step(1, 1, 0, 48'hDEADBEEF);
    n_cmp++;
    if (q48 !== q_before || f48 !== 1'b0 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL simul_full: got q=%h full=%b want q=%h full=0", q48, f48, q_before);
    end
    for (int k = 0; k < 511; k++) begin
      step(0, 1, 0, '0);
      n_cmp++;
      if ({obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
        n_fail++;
        $display("FAIL simul_full_drain[%0d]: got q=%h fl=%b want q=%h fl=%b", k, obs_q, obs_fl, exp_q(), exp_fl());
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i <= 2000; i++) begin
      step(i < 2000, i >= 1, 0, 48'(i));
      if (i >= 1) begin
        n_cmp++;
        if (q29 !== 29'(i - 1) || f29 !== 1'b0 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
          n_fail++;
          $display("FAIL wrap[%0d]: got q29=%h fl=%b want q29=%h fl=%b", i, q29, obs_fl, 29'(i - 1), exp_fl());
        end
      end
    end
  endtask

  task automatic test_clr();
    logic [47:0] w;
    for (int k = 0; k < 10; k++) step(1, 0, 0, rnd48());
    step(0, 1, 0, '0);
    step(1, 0, 1, rnd48());
    n_cmp++;
    if (q48 !== 48'h0 || e48 !== 1'b1 || f48 !== 1'b0 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL clr_flush: got q=%h fl=%b want q=0 fl=%b", obs_q, obs_fl, exp_fl());
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, '0);
      n_cmp++;
      if (q48 !== 48'h0 || e48 !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_rd_ignored: got q=%h empty=%b want q=0 empty=1", q48, e48);
      end
    end
    w = rnd48();
    step(1, 0, 0, w);
    step(0, 1, 0, '0);
    n_cmp++;
    if (q48 !== w || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL clr_first_word: got q=%h want q=%h", q48, w);
    end
  endtask

  task automatic test_random();
    int pw, pr;
    for (int i = 0; i < 3000; i++) begin
      pw = (i < 1500) ? 70 : 30;
      pr = (i < 1500) ? 30 : 70;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           $urandom_range(0, 199) == 0, rnd48());
      n_cmp++;
      if ({obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
        n_fail++;
        $display("FAIL random[%0d]: got q=%h fl=%b want q=%h fl=%b", i, obs_q, obs_fl, exp_q(), exp_fl());
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 5; k++) step(1, 0, 0, rnd48());
    step(0, 1, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    fifo_m.delete();
    mq = '0;
    n_cmp++;
    if (q48 !== 48'h0 || {obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL reset_mid: got q=%h fl=%b want q=0 fl=%b", obs_q, obs_fl, exp_fl());
    end
    rst_n = 1'b1;
    step(0, 1, 0, '0);
    n_cmp++;
    if ({obs_q, obs_fl} !== {exp_q(), exp_fl()}) begin
      n_fail++;
      $display("FAIL reset_mid_rd: got q=%h fl=%b want q=%h fl=%b", obs_q, obs_fl, exp_q(), exp_fl());
    end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_fill_overflow();
    test_simul_boundaries();
    test_wrap();
    test_clr();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
